// File: rtl/barcodescanner_nios_nios2_oci_dct_packer.sv
// barcodescanner_nios_nios2_oci_dct_packer: packs 2-bit trace atoms into frames for the trace FIFO.
module barcodescanner_nios_nios2_oci_dct_packer #(
   parameter int ATOM_W  = 2,
   parameter int DEPTH   = 15,
   parameter int COUNT_W = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      atom_valid,
   input  logic [ATOM_W-1:0]         atom_code,
   input  logic                      flush,
   output logic [ATOM_W*DEPTH-1:0]   dct_buffer,
   output logic [COUNT_W-1:0]        dct_count,
   output logic                      frame_valid,
   input  logic                      frame_ready,
   output logic [ATOM_W*DEPTH-1:0]   frame_data,
   output logic [COUNT_W-1:0]        frame_count,
   output logic                      overflow,
   input  logic                      overflow_clr,
   input  logic                      test_ending,
   output logic                      test_has_ended
);
   localparam int BW = ATOM_W * DEPTH;
   localparam logic [COUNT_W-1:0] FULL    = COUNT_W'(DEPTH);
   localparam logic [COUNT_W-1:0] FULL_M1 = COUNT_W'(DEPTH - 1);
   logic [BW-1:0]      pack_q, shifted, pack_a, pack_n, ld_data;
   logic [COUNT_W-1:0] cnt_q, cnt_a, cnt_n, ld_count;
   logic               pending, ending;
   logic               of, atom_in, stalled, start_end, flush_req, load, drop, pend_n, done;
   always_comb begin
      of        = !frame_valid || frame_ready;
      atom_in   = atom_valid && !ending;
      stalled   = cnt_q == FULL;
      start_end = test_ending && !ending;
      flush_req = flush || pending || start_end;
      shifted   = {pack_q[BW-ATOM_W-1:0], atom_code};
      load      = 1'b0;
      drop      = 1'b0;
      ld_data   = pack_q;
      ld_count  = cnt_q;
      pack_a    = pack_q;
      cnt_a     = cnt_q;
      // A full pack drains first; a same-cycle atom then starts the next pack.
      if (stalled) begin
         if (of) begin
            load   = 1'b1;
            pack_a = atom_in ? BW'(atom_code) : '0;
            cnt_a  = atom_in ? COUNT_W'(1) : '0;
         end else
            drop = atom_in;
      end else if (atom_in) begin
         if (cnt_q == FULL_M1 && of) begin
            load     = 1'b1;
            ld_data  = shifted;
            ld_count = FULL;
            pack_a   = '0;
            cnt_a    = '0;
         end else begin
            pack_a = shifted;
            cnt_a  = cnt_q + COUNT_W'(1);
         end
      end
      pack_n = pack_a;
      cnt_n  = cnt_a;
      pend_n = pending;
      // Flush sees the pack after this cycle's atom; it retries while the output is busy.
      if (flush_req) begin
         if (cnt_a == '0)
            pend_n = 1'b0;
         else if (of && !load) begin
            load     = 1'b1;
            ld_data  = pack_a;
            ld_count = cnt_a;
            pack_n   = '0;
            cnt_n    = '0;
            pend_n   = 1'b0;
         end else
            pend_n = 1'b1;
      end
      done = ending && cnt_q == '0 && !pending && !frame_valid;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pack_q         <= '0;
         cnt_q          <= '0;
         frame_valid    <= 1'b0;
         frame_data     <= '0;
         frame_count    <= '0;
         overflow       <= 1'b0;
         test_has_ended <= 1'b0;
         pending        <= 1'b0;
         ending         <= 1'b0;
      end else begin
         pack_q         <= pack_n;
         cnt_q          <= cnt_n;
         pending        <= pend_n;
         ending         <= ending || test_ending;
         overflow       <= drop || (overflow && !overflow_clr);
         test_has_ended <= test_has_ended || done;
         if (load) begin
            frame_valid <= 1'b1;
            frame_data  <= ld_data;
            frame_count <= ld_count;
         end else if (frame_ready)
            frame_valid <= 1'b0;
      end
   end
   assign dct_buffer = pack_q;
   assign dct_count  = cnt_q;
endmodule

// File: doc/barcodescanner_nios_nios2_oci_dct_packer.md
Name: barcodescanner_nios_nios2_oci_dct_packer

Overview:
- Producer side of the OCI direct-trace (DCT) channel.
- Packs 2-bit trace atoms from the CPU trace tap into a 30-bit buffer (15 atoms) with a 4-bit count. Presents the live dct_buffer/dct_count view to the OCI test bench.
- Hands completed or flushed frames to the trace FIFO over a valid/ready handshake.
- Drives the end-of-test sequence that produces test_has_ended.

Parameters:
- ATOM_W, 2, bits per trace atom.
- DEPTH, 15, atoms per frame. Buffer width = ATOM_W*DEPTH = 30.
- COUNT_W, 4, width of the atom counter. Must hold DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- atom_valid  in  1  atom_code valid this cycle.
- atom_code  in  2  trace atom; all four codes are legal.
- flush  in  1  single-cycle request to emit a partial frame.
- dct_buffer  out  30  live pack register; newest atom in [1:0].
- dct_count  out  4  atoms currently in pack register, 0..15.
- frame_valid  out  1  output frame register holds a frame.
- frame_ready  in  1  FIFO accepts the frame when frame_valid && frame_ready.
- frame_data  out  30  frame payload.
- frame_count  out  4  valid atoms in frame_data, 1..15.
- overflow  out  1  sticky: at least one atom was dropped.
- overflow_clr  in  1  clears overflow.
- test_ending  in  1  single-cycle pulse: drain and finish.
- test_has_ended  out  1  sticky: drain complete.

Behaviour:
- Reset (async assert, sync deassert by design of source): dct_buffer=0, dct_count=0, frame_valid=0, frame_data=0, frame_count=0, overflow=0, test_has_ended=0, pending-flush=0, ending=0.
- Output-free (OF) = !frame_valid || frame_ready.
- Atom accept, when count<15:
  - buffer <= {buffer[27:0], atom_code}; count <= count+1.
  - Unused upper bits stay 0.
- Fill: an atom that makes count 15 goes straight to the frame register if OF that cycle:
  - frame_data={buffer[27:0],code}, frame_count=15, frame_valid=1.
  - Pack resets to buffer=0, count=0.
  - Otherwise the pack holds 15 atoms (stalled).
- Stalled, count==15:
  - On the first cycle with OF, the pack moves to the frame register and the pack clears.
  - An atom arriving in that same cycle becomes the first atom of the new pack (count=1, buffer={28'b0,code}).
  - An atom arriving while stalled and !OF is dropped; overflow<=1.
- Flush, or flush latched as pending:
  - Applies after any same-cycle atom is taken in.
  - If count==0: no frame; pending clears.
  - If count>0 and OF: frame_data=buffer (including same-cycle atom), frame_count=count, frame_valid=1, pack clears, pending clears.
  - If !OF: pending=1; retried every cycle.
  - The same-cycle-atom rule means flush with count==14 plus an atom emits a 15-atom frame.
- Frame register:
  - Holds stable while frame_valid && !frame_ready.
  - Clears frame_valid on accept unless reloaded in the same cycle. A back-to-back reload keeps frame_valid=1.
- Overflow:
  - Sticky.
  - overflow_clr clears it; a same-cycle drop wins (stays 1).
- Ending:
  - test_ending latches ending=1 and implies flush.
  - While ending, atom_valid is ignored: no drop, no overflow.
  - test_has_ended<=1 the cycle after ending && count==0 && !pending && !frame_valid.
  - test_has_ended stays set until reset.
  - A repeat test_ending is ignored.
- Latency: atom to dct_buffer/dct_count is 1 cycle. Atom or flush to frame_valid is 1 cycle when OF.
- Reset mid-frame: all state is lost, frame_valid drops immediately, and no partial frame is emitted.

Test Plan:
- Reset, then 15 atoms 0,1,2,3,0,1,.. with frame_ready=1 -> frame_valid=1 one cycle after the 15th, frame_count=15, frame_data=30'h06C6C6C6 (oldest atom in [29:28]); dct_count=0.
- Flush: 3 atoms 3,2,1 then flush -> frame_data=30'h39, frame_count=3; flush with count=0 -> no frame.
- Backpressure: frame_ready=0, 30 atoms -> first frame held stable; pack stalls at count=15; 31st atom dropped, overflow=1. Raise frame_ready with an atom the same cycle -> second frame loaded back-to-back, dct_count=1.
- Flush while frame_valid && !frame_ready, count=5 -> pending; frame emitted (count 5) the cycle after frame_ready rises; overflow_clr with a concurrent drop -> overflow stays 1.
- Ending: count=7, test_ending, frame_ready=1 -> 7-atom frame; later atoms ignored; test_has_ended=1 the cycle after the frame is accepted, and remains set.
- Async reset asserted mid-stall (count=15, frame_valid=1) -> all outputs 0 without a clock edge.
